matmul_job_scheduler: RTL and testbench

Job queue and sequencer in front of `systolic_array_top`. It accepts matrix-multiply job descriptors (m, n, p, three base addresses, tag) into a small FIFO and launches them one at a time on the array with a single-cycle start pulse. It holds the configuration stable while the array runs, waits for `operation_done`, and returns a completion record with the measured cycle count. This turns the array into a back-to-back job engine and provides on-chip performance measurement.

---
 rtl/matmul_job_scheduler.sv | 180 ++++++++++++++++++
 tb/tb_matmul_job_scheduler.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matmul_job_scheduler.sv
// Job FIFO and launch sequencer for systolic_array_top: queues matmul descriptors,
// starts them one at a time, times each run and hands back a completion record.
module matmul_job_scheduler #(
  parameter int FIFO_DEPTH = 4,
  parameter int DIM_WIDTH  = 16,
  parameter int ADDR_WIDTH = 16,
  parameter int TAG_WIDTH  = 4,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            job_valid_i,
  output logic                            job_ready_o,
  input  logic [DIM_WIDTH-1:0]            job_m_i,
  input  logic [DIM_WIDTH-1:0]            job_n_i,
  input  logic [DIM_WIDTH-1:0]            job_p_i,
  input  logic [ADDR_WIDTH-1:0]           job_addr_a_i,
  input  logic [ADDR_WIDTH-1:0]           job_addr_b_i,
  input  logic [ADDR_WIDTH-1:0]           job_addr_c_i,
  input  logic [TAG_WIDTH-1:0]            job_tag_i,
  output logic                            start_o,
  output logic [DIM_WIDTH-1:0]            m_o,
  output logic [DIM_WIDTH-1:0]            n_o,
  output logic [DIM_WIDTH-1:0]            p_o,
  output logic [ADDR_WIDTH-1:0]           base_addr_a_o,
  output logic [ADDR_WIDTH-1:0]           base_addr_b_o,
  output logic [ADDR_WIDTH-1:0]           base_addr_c_o,
  input  logic                            operation_done_i,
  output logic                            done_valid_o,
  input  logic                            done_ready_i,
  output logic [TAG_WIDTH-1:0]            done_tag_o,
  output logic [CNT_WIDTH-1:0]            done_cycles_o,
  output logic                            done_err_o,
  output logic                            busy_o,
  output logic [$clog2(FIFO_DEPTH):0]     queue_level_o,
  output logic [CNT_WIDTH-1:0]            jobs_done_o,
  output logic [1:0]                      state_dbg_o
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, LAUNCH = 2'd1, RUN = 2'd2, REPORT = 2'd3} state_e;

  typedef struct packed {
    logic [TAG_WIDTH-1:0]  tag;
    logic [ADDR_WIDTH-1:0] addr_c;
    logic [ADDR_WIDTH-1:0] addr_b;
    logic [ADDR_WIDTH-1:0] addr_a;
    logic [DIM_WIDTH-1:0]  p;
    logic [DIM_WIDTH-1:0]  n;
    logic [DIM_WIDTH-1:0]  m;
  } job_t;

  // Handshakes: a job transfers on job_valid_i && job_ready_o, a record on
  // done_valid_o && done_ready_i; both sampled at the rising edge.
  job_t                 mem [FIFO_DEPTH];
  job_t                 job_in, head;
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]        level_q, level_d;
  logic                 push, pop, zero_dim;

  state_e               state_q, state_d;
  job_t                 cfg_q, cfg_d;
  logic                 err_q, err_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d, cycles_q, cycles_d, jobs_q, jobs_d;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  assign job_in   = '{tag: job_tag_i, addr_c: job_addr_c_i, addr_b: job_addr_b_i,
                      addr_a: job_addr_a_i, p: job_p_i, n: job_n_i, m: job_m_i};
  assign head     = mem[rd_ptr_q];
  assign zero_dim = (head.m == '0) || (head.n == '0) || (head.p == '0);

  assign job_ready_o = (level_q != LW'(FIFO_DEPTH));
  assign push        = job_valid_i && job_ready_o;
  assign pop         = (state_q == IDLE) && (level_q != '0);

  // Storage carries no reset; only the pointers and level define its contents.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= job_in;
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (level_q != '0) state_d = zero_dim ? REPORT : LAUNCH;
      LAUNCH:  state_d = RUN;
      RUN:     if (operation_done_i) state_d = REPORT;
      REPORT:  if (done_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    start_o      = (state_q == LAUNCH);
    done_valid_o = (state_q == REPORT);
    busy_o       = (state_q != IDLE);
    state_dbg_o  = state_q;
  end

  // Job registers, run timer and completion counter
  always_comb begin
    cfg_d    = cfg_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
    cycles_d = cycles_q;
    jobs_d   = jobs_q;
    case (state_q)
      IDLE: begin
        if (pop) begin
          cfg_d    = head;
          err_d    = zero_dim;
          cycles_d = '0;
        end
      end
      LAUNCH: cnt_d = '0;
      RUN: begin
        cnt_d = sat_inc(cnt_q);
        if (operation_done_i) cycles_d = sat_inc(cnt_q);
      end
      REPORT:  if (done_ready_i) jobs_d = jobs_q + CNT_WIDTH'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      cfg_q    <= '0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
      cycles_q <= '0;
      jobs_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      cfg_q    <= cfg_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
      cycles_q <= cycles_d;
      jobs_q   <= jobs_d;
    end
  end

  assign m_o           = cfg_q.m;
  assign n_o           = cfg_q.n;
  assign p_o           = cfg_q.p;
  assign base_addr_a_o = cfg_q.addr_a;
  assign base_addr_b_o = cfg_q.addr_b;
  assign base_addr_c_o = cfg_q.addr_c;
  assign done_tag_o    = cfg_q.tag;
  assign done_cycles_o = cycles_q;
  assign done_err_o    = err_q;
  assign queue_level_o = level_q;
  assign jobs_done_o   = jobs_q;

endmodule

// File: tb/tb_matmul_job_scheduler.sv
// Directed bench for matmul_job_scheduler with a delay-line model of the array
// and an in-order scoreboard of expected completion records.
module tb_matmul_job_scheduler;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        job_valid_i, job_ready_o;
  logic [15:0] job_m_i, job_n_i, job_p_i;
  logic [15:0] job_addr_a_i, job_addr_b_i, job_addr_c_i;
  logic [3:0]  job_tag_i;
  logic        start_o;
  logic [15:0] m_o, n_o, p_o, base_addr_a_o, base_addr_b_o, base_addr_c_o;
  logic        operation_done_i;
  logic        done_valid_o, done_ready_i;
  logic [3:0]  done_tag_o;
  logic [31:0] done_cycles_o;
  logic        done_err_o, busy_o;
  logic [2:0]  queue_level_o;
  logic [31:0] jobs_done_o;
  logic [1:0]  state_dbg_o;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  matmul_job_scheduler dut (
    .clk(clk), .reset_n(reset_n),
    .job_valid_i(job_valid_i), .job_ready_o(job_ready_o),
    .job_m_i(job_m_i), .job_n_i(job_n_i), .job_p_i(job_p_i),
    .job_addr_a_i(job_addr_a_i), .job_addr_b_i(job_addr_b_i), .job_addr_c_i(job_addr_c_i),
    .job_tag_i(job_tag_i), .start_o(start_o),
    .m_o(m_o), .n_o(n_o), .p_o(p_o),
    .base_addr_a_o(base_addr_a_o), .base_addr_b_o(base_addr_b_o), .base_addr_c_o(base_addr_c_o),
    .operation_done_i(operation_done_i),
    .done_valid_o(done_valid_o), .done_ready_i(done_ready_i),
    .done_tag_o(done_tag_o), .done_cycles_o(done_cycles_o), .done_err_o(done_err_o),
    .busy_o(busy_o), .queue_level_o(queue_level_o), .jobs_done_o(jobs_done_o),
    .state_dbg_o(state_dbg_o)
  );

  task automatic check_eq(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0d expected=%0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Array model: raises done in the arr_lat-th RUN cycle after the start pulse.
  int   arr_lat  = 10;
  int   arr_left = 0;
  logic model_done = 1'b0;
  logic spur_done  = 1'b0;
  assign operation_done_i = model_done | spur_done;

  always @(negedge clk) begin
    if (!reset_n)        arr_left = 0;
    else if (start_o)    arr_left = arr_lat + 1;
    else if (arr_left > 0) arr_left--;
    model_done = (arr_left == 1);
  end

  // Scoreboard: expected record = {err, tag, cycles}
  logic [36:0] exp_q[$];
  logic        prev_start = 1'b0;
  int          n_starts = 0;
  int          last_start_cyc = -1;
  int          n_hs = 0;
  int          acc_cyc = 0;

  always @(negedge clk) begin
    logic [36:0] e;
    if (start_o) begin
      check_eq("start_one_cycle", prev_start, 0);
      n_starts++;
      last_start_cyc = cyc;
    end
    prev_start = start_o;
    if (done_valid_o && done_ready_i) begin
      n_hs++;
      if (exp_q.size() == 0) check_eq("unexpected_record", 1, 0);
      else begin
        e = exp_q.pop_front();
        check_eq("rec_tag", done_tag_o, e[35:32]);
        check_eq("rec_cycles", done_cycles_o, e[31:0]);
        check_eq("rec_err", done_err_o, e[36]);
      end
    end
  end

  // driver tasks (entered and left at posedge + 1)
  task automatic push_job(input logic [3:0] tag, input logic [15:0] m, input logic [15:0] n,
                          input logic [15:0] p);
    int   waited = 0;
    logic err;
    err = (m == 0) || (n == 0) || (p == 0);
    job_valid_i  = 1'b1;
    job_tag_i    = tag;
    job_m_i      = m;
    job_n_i      = n;
    job_p_i      = p;
    job_addr_a_i = {tag, 12'h100};
    job_addr_b_i = {tag, 12'h200};
    job_addr_c_i = {tag, 12'h300};
    while (!job_ready_o && waited < 100) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!job_ready_o) begin
      check_eq("push_timeout", 1, 0);
    end else begin
      exp_q.push_back({err, tag, err ? 32'd0 : 32'(arr_lat)});
      @(posedge clk); #1;
      acc_cyc = cyc;
    end
    job_valid_i = 1'b0;
  endtask

  task automatic wait_drain(input int max_cyc);
    int i = 0;
    while ((exp_q.size() != 0 || busy_o) && i < max_cyc) begin
      @(posedge clk); #1;
      i++;
    end
    check_eq("drain_in_time", (exp_q.size() == 0 && !busy_o), 1);
  endtask

  task automatic wait_record(input int max_cyc);
    int i = 0;
    while (!done_valid_o && i < max_cyc) begin
      @(posedge clk); #1;
      i++;
    end
    check_eq("record_in_time", done_valid_o, 1);
  endtask

  int base;
  int hs;
  int hs_base = 0;

  initial begin
    reset_n = 1'b0;
    job_valid_i = 1'b0; job_tag_i = '0;
    job_m_i = '0; job_n_i = '0; job_p_i = '0;
    job_addr_a_i = '0; job_addr_b_i = '0; job_addr_c_i = '0;
    done_ready_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_level", queue_level_o, 0);
    check_eq("rst_ready", job_ready_o, 1);
    check_eq("rst_start", start_o, 0);
    check_eq("rst_valid", done_valid_o, 0);
    check_eq("rst_err", done_err_o, 0);
    check_eq("rst_m", m_o, 0);
    check_eq("rst_addr_c", base_addr_c_o, 0);
    check_eq("rst_cycles", done_cycles_o, 0);
    check_eq("rst_jobs", jobs_done_o, 0);
    check_eq("rst_busy", busy_o, 0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // single 64x64x64 job, 100-cycle run
    arr_lat = 100;
    base = n_starts;
    push_job(4'd3, 16'd64, 16'd64, 16'd64);
    repeat (3) begin @(posedge clk); #1; end
    check_eq("t1_start_latency", last_start_cyc, acc_cyc + 1);
    repeat (40) begin @(posedge clk); #1; end
    check_eq("t1_m_run", m_o, 64);
    check_eq("t1_n_run", n_o, 64);
    check_eq("t1_p_run", p_o, 64);
    check_eq("t1_addr_a", base_addr_a_o, 16'h3100);
    check_eq("t1_busy", busy_o, 1);
    wait_drain(200);
    check_eq("t1_starts", n_starts - base, 1);
    check_eq("t1_jobs", jobs_done_o, 1);
    check_eq("t1_m_idle", m_o, 64);

    // five back-to-back jobs into a four-deep queue
    arr_lat = 20;
    base = n_starts;
    push_job(4'd4, 16'd2, 16'd3, 16'd4);
    push_job(4'd5, 16'd5, 16'd6, 16'd7);
    push_job(4'd6, 16'd8, 16'd9, 16'd10);
    push_job(4'd7, 16'd11, 16'd12, 16'd13);
    push_job(4'd8, 16'd14, 16'd15, 16'd16);
    check_eq("t2_level_full", queue_level_o, 4);
    check_eq("t2_ready_low", job_ready_o, 0);
    wait_drain(400);
    check_eq("t2_starts", n_starts - base, 5);
    check_eq("t2_jobs", jobs_done_o, 6);

    // zero-dimension job alone, record held
    done_ready_i = 1'b0;
    base = n_starts;
    push_job(4'd2, 16'd0, 16'd7, 16'd7);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_eq("t3_zero_valid", done_valid_o, 1);
    check_eq("t3_zero_err", done_err_o, 1);
    check_eq("t3_zero_cycles", done_cycles_o, 0);
    done_ready_i = 1'b1;
    wait_drain(50);
    // zero job between two valid jobs
    arr_lat = 15;
    push_job(4'd9, 16'd5, 16'd5, 16'd5);
    push_job(4'd10, 16'd5, 16'd0, 16'd5);
    push_job(4'd11, 16'd1, 16'd1, 16'd1);
    wait_drain(300);
    check_eq("t3_starts", n_starts - base, 2);
    check_eq("t3_jobs", jobs_done_o, n_hs - hs_base);

    // consumer stalls 20 cycles in REPORT
    done_ready_i = 1'b0;
    arr_lat = 10;
    base = n_starts;
    push_job(4'd12, 16'd3, 16'd3, 16'd3);
    wait_record(50);
    push_job(4'd13, 16'd4, 16'd4, 16'd4);
    push_job(4'd14, 16'd4, 16'd4, 16'd4);
    check_eq("t4_level", queue_level_o, 2);
    repeat (20) begin
      @(posedge clk); #1;
      check_eq("t4_hold_valid", done_valid_o, 1);
      check_eq("t4_hold_tag", done_tag_o, 12);
      check_eq("t4_hold_cycles", done_cycles_o, 10);
    end
    check_eq("t4_no_start", n_starts - base, 1);
    done_ready_i = 1'b1;
    @(posedge clk); #1;
    hs = cyc;
    repeat (3) begin @(posedge clk); #1; end
    check_eq("t4_relaunch", last_start_cyc, hs + 1);
    wait_drain(200);
    check_eq("t4_starts", n_starts - base, 3);

    // spurious done in IDLE and REPORT, then done in first RUN cycle
    base = n_starts;
    spur_done = 1'b1;
    @(posedge clk); #1;
    spur_done = 1'b0;
    check_eq("t5_idle_busy", busy_o, 0);
    check_eq("t5_idle_valid", done_valid_o, 0);
    done_ready_i = 1'b0;
    arr_lat = 5;
    push_job(4'd15, 16'd2, 16'd2, 16'd2);
    wait_record(30);
    spur_done = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    spur_done = 1'b0;
    check_eq("t5_rep_cycles", done_cycles_o, 5);
    check_eq("t5_rep_state", state_dbg_o, 3);
    done_ready_i = 1'b1;
    wait_drain(30);
    arr_lat = 1;
    push_job(4'd1, 16'd1, 16'd2, 16'd3);
    wait_drain(30);
    check_eq("t5_starts", n_starts - base, 2);
    check_eq("t5_jobs", jobs_done_o, n_hs - hs_base);

    // reset in the middle of a run with two jobs queued
    arr_lat = 200;
    push_job(4'd6, 16'd8, 16'd8, 16'd8);
    push_job(4'd7, 16'd8, 16'd8, 16'd8);
    push_job(4'd8, 16'd8, 16'd8, 16'd8);
    repeat (10) begin @(posedge clk); #1; end
    check_eq("t6_running", state_dbg_o, 2);
    check_eq("t6_queued", queue_level_o, 2);
    #2 reset_n = 1'b0;
    #1;
    check_eq("t6_rst_start", start_o, 0);
    check_eq("t6_rst_level", queue_level_o, 0);
    check_eq("t6_rst_ready", job_ready_o, 1);
    check_eq("t6_rst_busy", busy_o, 0);
    check_eq("t6_rst_valid", done_valid_o, 0);
    check_eq("t6_rst_m", m_o, 0);
    check_eq("t6_rst_jobs", jobs_done_o, 0);
    exp_q.delete();
    hs_base = n_hs;
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    arr_lat = 7;
    base = n_starts;
    push_job(4'd5, 16'd2, 16'd2, 16'd2);
    wait_drain(50);
    check_eq("t6_after_starts", n_starts - base, 1);
    check_eq("t6_after_jobs", jobs_done_o, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
